// File: rtl/vx_mem_arbiter_if.sv
// vx_mem_arbiter_if: request/response bundle for one memory-style port
interface vx_mem_arbiter_if #(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int BYTEEN_WIDTH = 64,
    parameter int TAG_WIDTH    = 56
);
    logic                    req_valid;
    logic                    req_rw;
    logic [BYTEEN_WIDTH-1:0] req_byteen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    req_ready;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/vx_mem_arbiter.sv
// vx_mem_arbiter: round-robin core/host arbiter onto one local_memory port with read throttling
module vx_mem_arbiter #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 26,
    parameter int BYTEEN_WIDTH    = 64,
    parameter int TAG_WIDTH       = 56,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic               clk,
    input  logic               reset,
    vx_mem_arbiter_if.slave    rq0,
    vx_mem_arbiter_if.slave    rq1,
    vx_mem_arbiter_if.master   mem,
    output logic               busy,
    output logic               rsp_err
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt0, cnt1;
    logic rr, elig0, elig1, slot_free, fire0, fire1;
    logic rsp_id, rsp_fire, inc0, inc1, dec0, dec1;

    // Eligibility, round-robin grant and handshake decode for both paths
    always_comb begin
        elig0     = rq0.req_valid && !(!rq0.req_rw && cnt0 == CNT_MAX);
        elig1     = rq1.req_valid && !(!rq1.req_rw && cnt1 == CNT_MAX);
        slot_free = !mem.req_valid || mem.req_ready;
        fire0     = slot_free && elig0 && (!elig1 || !rr);
        fire1     = slot_free && elig1 && (!elig0 || rr);
        rsp_id    = mem.rsp_tag[TAG_WIDTH];
        rsp_fire  = mem.rsp_valid && (rsp_id ? rq1.rsp_ready : rq0.rsp_ready);
        inc0      = fire0 && !rq0.req_rw;
        inc1      = fire1 && !rq1.req_rw;
        dec0      = rsp_fire && !rsp_id;
        dec1      = rsp_fire && rsp_id;
    end

    assign rq0.req_ready = fire0;
    assign rq1.req_ready = fire1;
    assign rq0.rsp_valid = mem.rsp_valid && !rsp_id;
    assign rq1.rsp_valid = mem.rsp_valid && rsp_id;
    assign rq0.rsp_data  = mem.rsp_data;
    assign rq1.rsp_data  = mem.rsp_data;
    assign rq0.rsp_tag   = mem.rsp_tag[TAG_WIDTH-1:0];
    assign rq1.rsp_tag   = mem.rsp_tag[TAG_WIDTH-1:0];
    assign mem.rsp_ready = rsp_id ? rq1.rsp_ready : rq0.rsp_ready;
    assign busy          = mem.req_valid || cnt0 != '0 || cnt1 != '0;

    // One-entry output stage: load the granted request, drain when memory accepts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.req_valid  <= 1'b0;
            mem.req_rw     <= 1'b0;
            mem.req_byteen <= '0;
            mem.req_addr   <= '0;
            mem.req_data   <= '0;
            mem.req_tag    <= '0;
            rr             <= 1'b0;
        end else if (fire0 || fire1) begin
            mem.req_valid  <= 1'b1;
            mem.req_rw     <= fire1 ? rq1.req_rw     : rq0.req_rw;
            mem.req_byteen <= fire1 ? rq1.req_byteen : rq0.req_byteen;
            mem.req_addr   <= fire1 ? rq1.req_addr   : rq0.req_addr;
            mem.req_data   <= fire1 ? rq1.req_data   : rq0.req_data;
            mem.req_tag    <= fire1 ? {1'b1, rq1.req_tag} : {1'b0, rq0.req_tag};
            rr             <= fire0;
        end else if (mem.req_ready) begin
            mem.req_valid  <= 1'b0;
        end
    end

    // Outstanding-read tracking; a response with nothing outstanding is dropped and flagged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0    <= '0;
            cnt1    <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt0 <= cnt0 + CW'(inc0) - CW'(dec0 && cnt0 != '0);
            cnt1 <= cnt1 + CW'(inc1) - CW'(dec1 && cnt1 != '0);
            if ((dec0 && cnt0 == '0) || (dec1 && cnt1 == '0))
                rsp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vx_mem_arbiter.sv
// tb_vx_mem_arbiter: directed and randomized checks of vx_mem_arbiter against a transaction-level model
module tb_vx_mem_arbiter;
    localparam int DW = 64, AW = 26, BW = 8, TW = 16, MO = 16;

    typedef struct packed {
        logic          rw;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW:0]   tag;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vx_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(BW), .TAG_WIDTH(TW))   rq0_if ();
    vx_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(BW), .TAG_WIDTH(TW))   rq1_if ();
    vx_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(BW), .TAG_WIDTH(TW+1)) mem_if ();

    logic          rv [2];
    logic          rw [2];
    logic [BW-1:0] rbe [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    logic [TW-1:0] rt [2];
    logic          rrdy [2];
    logic          mreq_rdy, mrsp_v;
    logic [DW-1:0] mrsp_d;
    logic [TW:0]   mrsp_t;
    logic          busy, rsp_err;

    assign rq0_if.req_valid  = rv[0];
    assign rq0_if.req_rw     = rw[0];
    assign rq0_if.req_byteen = rbe[0];
    assign rq0_if.req_addr   = ra[0];
    assign rq0_if.req_data   = rd[0];
    assign rq0_if.req_tag    = rt[0];
    assign rq0_if.rsp_ready  = rrdy[0];
    assign rq1_if.req_valid  = rv[1];
    assign rq1_if.req_rw     = rw[1];
    assign rq1_if.req_byteen = rbe[1];
    assign rq1_if.req_addr   = ra[1];
    assign rq1_if.req_data   = rd[1];
    assign rq1_if.req_tag    = rt[1];
    assign rq1_if.rsp_ready  = rrdy[1];
    assign mem_if.req_ready  = mreq_rdy;
    assign mem_if.rsp_valid  = mrsp_v;
    assign mem_if.rsp_data   = mrsp_d;
    assign mem_if.rsp_tag    = mrsp_t;

    vx_mem_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTEEN_WIDTH(BW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .rq0(rq0_if), .rq1(rq1_if), .mem(mem_if),
        .busy(busy), .rsp_err(rsp_err)
    );

    // Reference model: pending-issue queue (holds at most the staged request), read counts, rr, error flag
    req_t q[$];
    int   cnt [2];
    logic rr_m, err_m;
    int   g;
    int   passed = 0, total = 0;
    logic [127:0] held;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        cnt[0] = 0;
        cnt[1] = 0;
        rr_m = 1'b0;
        err_m = 1'b0;
    endtask

    function automatic int grant_of();
        logic e0, e1;
        e0 = rv[0] && !(!rw[0] && cnt[0] == MO);
        e1 = rv[1] && !(!rw[1] && cnt[1] == MO);
        if (!(q.size() == 0 || mreq_rdy)) return -1;
        if (e0 && e1) return rr_m ? 1 : 0;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; rbe[i] = '0; ra[i] = '0; rd[i] = '0; rt[i] = '0; rrdy[i] = 1'b1;
        end
        mreq_rdy = 1'b1;
        mrsp_v = 1'b0;
        mrsp_d = '0;
        mrsp_t = '0;
    endtask

    task automatic rand_inputs(input int pv, input int pw, input int pmr, input int prsp, input int pbogus);
        logic id;
        for (int i = 0; i < 2; i++) begin
            rv[i]   = $urandom_range(99) < pv;
            rw[i]   = $urandom_range(99) < pw;
            rbe[i]  = BW'($urandom);
            ra[i]   = AW'($urandom);
            rd[i]   = {$urandom, $urandom};
            rt[i]   = TW'($urandom);
            rrdy[i] = $urandom_range(99) < 80;
        end
        mreq_rdy = $urandom_range(99) < pmr;
        id = 1'($urandom_range(1));
        mrsp_v = (cnt[id] > 0 && $urandom_range(99) < prsp) || $urandom_range(99) < pbogus;
        mrsp_t = {id, TW'($urandom)};
        mrsp_d = {$urandom, $urandom};
    endtask

    // Compare every DUT output against the model just before the edge
    task automatic sample();
        logic id;
        @(negedge clk);
        g = grant_of();
        id = mrsp_t[TW];
        check("rq0_req_ready", rq0_if.req_ready, g == 0);
        check("rq1_req_ready", rq1_if.req_ready, g == 1);
        check("mem_req_valid", mem_if.req_valid, q.size() != 0);
        if (q.size() != 0)
            check("mem_req", {mem_if.req_rw, mem_if.req_byteen, mem_if.req_addr, mem_if.req_data, mem_if.req_tag}, q[0]);
        check("rq0_rsp_valid", rq0_if.rsp_valid, mrsp_v && !id);
        check("rq1_rsp_valid", rq1_if.rsp_valid, mrsp_v && id);
        if (mrsp_v) begin
            check("rsp_tag", id ? rq1_if.rsp_tag : rq0_if.rsp_tag, mrsp_t[TW-1:0]);
            check("rsp_data", id ? rq1_if.rsp_data : rq0_if.rsp_data, mrsp_d);
        end
        check("mem_rsp_ready", mem_if.rsp_ready, rrdy[id]);
        check("busy", busy, q.size() != 0 || cnt[0] != 0 || cnt[1] != 0);
        check("rsp_err", rsp_err, err_m);
    endtask

    task automatic advance();
        logic id;
        req_t r;
        @(posedge clk);
        id = mrsp_t[TW];
        if (mrsp_v && rrdy[id]) begin
            if (cnt[id] == 0) err_m = 1'b1;
            else cnt[id]--;
        end
        if (q.size() != 0 && mreq_rdy) void'(q.pop_front());
        if (g >= 0) begin
            r = {rw[g], rbe[g], ra[g], rd[g], g[0], rt[g]};
            q.push_back(r);
            rr_m = (g == 0);
            if (!rw[g]) cnt[g]++;
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid", mem_if.req_valid, 0);
        check("rst_mem_tag", mem_if.req_tag, 0);
        check("rst_mem_addr", mem_if.req_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_err", rsp_err, 0);
        reset = 1'b1;

        // Single core read and its response
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 26'h10; rt[0] = 16'h5;
        sample();
        check("t1_accept", rq0_if.req_ready, 1);
        advance();
        idle();
        sample();
        check("t1_valid", mem_if.req_valid, 1);
        check("t1_tag", mem_if.req_tag, 17'h00005);
        check("t1_addr", mem_if.req_addr, 26'h10);
        check("t1_busy", busy, 1);
        advance();
        mrsp_v = 1'b1; mrsp_t = {1'b0, 16'h5}; mrsp_d = 64'hdead_beef_0123_4567;
        sample();
        check("t1_rsp0", rq0_if.rsp_valid, 1);
        check("t1_rsp1", rq1_if.rsp_valid, 0);
        check("t1_rsp_tag", rq0_if.rsp_tag, 16'h5);
        advance();
        idle();
        sample();
        check("t1_busy_done", busy, 0);
        advance();

        // Both requesters always valid: grants alternate starting with host (core was last)
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 2; i++) begin
                rv[i] = 1'b1; rw[i] = 1'b1; ra[i] = AW'($urandom); rd[i] = {$urandom, $urandom}; rt[i] = TW'($urandom);
            end
            sample();
            check("t2_grant0", rq0_if.req_ready, k[0]);
            check("t2_grant1", rq1_if.req_ready, !k[0]);
            advance();
        end

        // Memory back-pressure: staged request must hold and nobody is accepted
        mreq_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 2; i++) begin
                ra[i] = AW'($urandom); rd[i] = {$urandom, $urandom};
            end
            sample();
            if (k == 0) held = {mem_if.req_rw, mem_if.req_byteen, mem_if.req_addr, mem_if.req_data, mem_if.req_tag};
            check("t3_hold", {mem_if.req_rw, mem_if.req_byteen, mem_if.req_addr, mem_if.req_data, mem_if.req_tag}, held);
            check("t3_stall0", rq0_if.req_ready, 0);
            check("t3_stall1", rq1_if.req_ready, 0);
            advance();
        end
        mreq_rdy = 1'b1;
        step();
        idle();
        step();
        step();

        // Core read throttling at MAX_OUTSTANDING
        rv[0] = 1'b1; rw[0] = 1'b0;
        for (int k = 0; k < MO; k++) begin
            ra[0] = AW'($urandom); rt[0] = TW'($urandom);
            sample();
            check("t4_accept", rq0_if.req_ready, 1);
            advance();
        end
        sample();
        check("t4_stall", rq0_if.req_ready, 0);
        advance();
        rv[1] = 1'b1; rw[1] = 1'b0;
        sample();
        check("t4_host", rq1_if.req_ready, 1);
        check("t4_core_blocked", rq0_if.req_ready, 0);
        advance();
        rv[1] = 1'b0; rw[0] = 1'b1;
        sample();
        check("t4_core_write", rq0_if.req_ready, 1);
        advance();
        rw[0] = 1'b0;
        mrsp_v = 1'b1; mrsp_t = {1'b0, 16'h0042};
        sample();
        check("t4_still_full", rq0_if.req_ready, 0);
        advance();
        sample();
        check("t4_freed", rq0_if.req_ready, 1);
        advance();
        mrsp_v = 1'b0;
        sample();
        check("t5_same_cycle", rq0_if.req_ready, 1);
        advance();
        sample();
        check("t5_full_again", rq0_if.req_ready, 0);
        advance();

        // Host response drains its only read; a second one is spurious
        rv[0] = 1'b0;
        mrsp_v = 1'b1; mrsp_t = {1'b1, 16'h0077};
        step();
        sample();
        check("t5_err_pending", rsp_err, 0);
        advance();
        mrsp_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t5_err_sticky", rsp_err, 1);
            advance();
        end

        // Reset with a staged request and three reads in flight
        reset = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rv[0] = 1'b1; rw[0] = 1'b0;
        repeat (3) step();
        rw[0] = 1'b1; mreq_rdy = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("t6_valid", mem_if.req_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_err", rsp_err, 0);
        idle();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mrsp_v = 1'b1; mrsp_t = {1'b0, 16'h0003};
        step();
        mrsp_v = 1'b0;
        sample();
        check("t6_err_after", rsp_err, 1);
        advance();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic in several load regimes
        for (int k = 0; k < 1500; k++) begin
            rand_inputs(70, 30, 70, 60, 0);
            step();
        end
        for (int k = 0; k < 1000; k++) begin
            rand_inputs(90, 10, 90, 10, 0);
            step();
        end
        for (int k = 0; k < 1000; k++) begin
            rand_inputs(50, 50, 30, 50, 3);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vx_mem_arbiter.md
Name: vx_mem_arbiter

Overview:
- Two-requester arbiter sharing one local_memory port between the Vortex core (requester 0) and a host/loader port (requester 1), e.g. for program load and result readback.
- Requests are round-robin arbitrated into a one-entry registered output stage.
- The requester ID is appended as the tag MSB; responses are routed back by that bit.
- Per-requester outstanding-read counters throttle requesters and drive a busy status.

Parameters:
- DATA_WIDTH, 512, memory data width
- ADDR_WIDTH, 26, line address width
- BYTEEN_WIDTH, 64, byte-enable width (DATA_WIDTH/8)
- TAG_WIDTH, 56, requester tag width; memory-side tag is TAG_WIDTH+1
- MAX_OUTSTANDING, 16, max in-flight reads per requester (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rq_req_valid[i]  in  1  request valid, i=0 core, i=1 host (per-requester ports rq0_*/rq1_*)
- rq_req_rw[i]  in  1  1=write, 0=read
- rq_req_byteen[i]  in  BYTEEN_WIDTH  write byte enables
- rq_req_addr[i]  in  ADDR_WIDTH  address
- rq_req_data[i]  in  DATA_WIDTH  write data
- rq_req_tag[i]  in  TAG_WIDTH  requester tag
- rq_req_ready[i]  out  1  request accepted this cycle
- rq_rsp_valid[i]  out  1  response valid
- rq_rsp_data[i]  out  DATA_WIDTH  read data
- rq_rsp_tag[i]  out  TAG_WIDTH  original tag
- rq_rsp_ready[i]  in  1  requester accepts response
- mem_req_valid / rw / byteen / addr / data  out  1/1/BYTEEN_WIDTH/ADDR_WIDTH/DATA_WIDTH  to local_memory
- mem_req_tag  out  TAG_WIDTH+1  {req_id, tag}
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  DATA_WIDTH  read data
- mem_rsp_tag  in  TAG_WIDTH+1  returned tag
- mem_rsp_ready  out  1  arbiter accepts response
- busy  out  1  output stage occupied or any read outstanding
- rsp_err  out  1  sticky: response arrived for a requester with zero outstanding reads

Behaviour:
Reset (reset=0, async):
- out_valid=0, so mem_req_valid=0; all mem_req_* data fields 0.
- Both counters 0; rr pointer=0 (core favoured first); rsp_err=0; busy=0.
- Asserting reset mid-transaction drops the staged request and all in-flight tracking; responses received after release that have a zero counter set rsp_err.

Request path:
- eligible[i] = rq_req_valid[i] && !(rq_req_rw[i]==0 && cnt[i]==MAX_OUTSTANDING). Writes are never throttled.
- slot_free = !out_valid || mem_req_ready.
- Grant: if both eligible, grant rr pointer; otherwise grant the single eligible requester.
- rq_req_ready[i] = slot_free && grant[i] (combinational, no dependency on rq_req_ready).
- On grant handshake: output register loads the request with tag {i, rq_req_tag[i]}; out_valid=1 next cycle; rr pointer <= ~i.
- rr pointer is unchanged when no grant occurs.
- Latency: request accepted in cycle N appears on mem_req_* in N+1.
- Full throughput: one request per cycle while mem_req_ready=1.
- mem_req_* holds stable while mem_req_valid && !mem_req_ready.
- out_valid clears when mem_req_ready=1 and no new grant occurs.

Response path (combinational pass-through):
- id = mem_rsp_tag[TAG_WIDTH].
- rq_rsp_valid[id] = mem_rsp_valid; the other requester's rq_rsp_valid = 0.
- rq_rsp_tag/data = mem_rsp_tag[TAG_WIDTH-1:0] / mem_rsp_data.
- mem_rsp_ready = rq_rsp_ready[id].

Counters:
- cnt[i] increments on a read handshake into the output stage.
- cnt[i] decrements on a response handshake with id=i.
- Simultaneous increment and decrement on the same i leaves cnt[i] unchanged.
- Width is clog2(MAX_OUTSTANDING)+1; never wraps.
- A decrement at cnt=0 is suppressed and sets rsp_err; rsp_err clears only on reset.
- busy = out_valid || cnt[0]!=0 || cnt[1]!=0, registered-state derived.

Test Plan:
- Reset, then core read addr 0x10 tag 0x5 -> mem_req_valid in next cycle with tag {0,0x5}; busy=1; response tag {0,0x5} -> rq0_rsp_valid only; busy=0 after handshake.
- Both requesters valid every cycle with mem_req_ready=1 -> grants alternate 0,1,0,1 at one per cycle; no starvation.
- mem_req_ready=0 for 5 cycles with request staged -> mem_req_* stable; rq_req_ready=0 for both; the staged request issues once on ready=1.
- Core issues 16 reads with no responses -> 17th core read stalls (rq0_req_ready=0); host reads and core writes still granted; one response frees the slot.
- Same-cycle core read handshake and core response -> cnt[0] unchanged; response tag {1,x} with cnt[1]=0 -> rsp_err=1 and stays 1.
- Reset asserted while out_valid=1 and cnt=3 -> mem_req_valid=0 immediately; counters 0; busy=0.
